// File: rtl/mem4x4_pkg.sv
// rtl/mem4x4_pkg.sv - shared types, defaults and reset table for the 4x4 lookup memory controller
package mem4x4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        SCAN = 2'd3
    } state_t;

    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_SCAN_DIV   = 4;

    // Word i sits in bits [4i+3:4i]: 0011, 0110, 1001, 1100.
    localparam logic [15:0] MEM_INIT = 16'hC963;

    function automatic logic [3:0] mem_init_word(input int idx);
        return MEM_INIT[(idx % 4) * 4 +: 4];
    endfunction

endpackage

// File: rtl/mem4x4_ctrl_scan_divider.sv
// rtl/mem4x4_ctrl_scan_divider.sv - scan pacing counter with hold-at-terminal and clear
module scan_divider #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic idle,
    input  logic clr,
    output logic due
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          due_q, due_d;

    // due_q latches once the terminal count has been seen and stays set
    // until the scan step actually runs, so a deferred step is never lost.
    always_comb begin
        cnt_d = cnt_q;
        due_d = due_q;
        if (!en || clr) begin
            cnt_d = '0;
            due_d = 1'b0;
        end else if (idle && !due_q) begin
            if (cnt_q == TERM) begin
                due_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            due_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            due_q <= due_d;
        end
    end

    assign due = due_q && en;

endmodule

// File: rtl/mem4x4_ctrl.sv
// rtl/mem4x4_ctrl.sv - single-slot arbiter for write, read and scan access to the 4x4 lookup memory
module mem4x4_ctrl
    import mem4x4_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
    input  logic                  clk_2,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  scan_en,
    output logic [ADDR_WIDTH-1:0] scan_addr,
    output logic [DATA_WIDTH-1:0] scan_data,
    output logic                  scan_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  wr_ack_q, wr_ack_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  scan_valid_q, scan_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] scan_data_q, scan_data_d;
    logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
    logic                  scan_due;

    scan_divider #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_divider (
        .clk  (clk_2),
        .rst_n(rst_n),
        .en   (scan_en),
        .idle (state_q == IDLE),
        .clr  (state_q == SCAN),
        .due  (scan_due)
    );

    always_comb begin
        state_d      = state_q;
        op_addr_d    = op_addr_q;
        op_data_d    = op_data_q;
        mem_d        = mem_q;
        wr_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        scan_valid_d = 1'b0;
        rd_data_d    = rd_data_q;
        scan_data_d  = scan_data_q;
        scan_addr_d  = scan_addr_q;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    op_addr_d = wr_addr;
                    op_data_d = wr_data;
                    state_d   = WR;
                end else if (rd_req) begin
                    op_addr_d = rd_addr;
                    state_d   = RD;
                end else if (scan_due) begin
                    state_d = SCAN;
                end
            end
            WR: begin
                mem_d[op_addr_q] = op_data_q;
                wr_ack_d         = 1'b1;
                state_d          = IDLE;
            end
            RD: begin
                rd_data_d  = mem_q[op_addr_q];
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            SCAN: begin
                scan_data_d  = mem_q[scan_addr_q];
                scan_valid_d = 1'b1;
                scan_addr_d  = scan_addr_q + 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset restores the lookup table, so an aborted write leaves no trace.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_addr_q    <= '0;
            op_data_q    <= '0;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            rd_data_q    <= '0;
            scan_data_q  <= '0;
            scan_addr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(mem_init_word(i));
            end
        end else begin
            state_q      <= state_d;
            op_addr_q    <= op_addr_d;
            op_data_q    <= op_data_d;
            wr_ack_q     <= wr_ack_d;
            rd_valid_q   <= rd_valid_d;
            scan_valid_q <= scan_valid_d;
            rd_data_q    <= rd_data_d;
            scan_data_q  <= scan_data_d;
            scan_addr_q  <= scan_addr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign wr_ack     = wr_ack_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_data_q;
    assign scan_addr  = scan_addr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem4x4_ctrl.sv
// tb/tb_mem4x4_ctrl.sv - directed self-checking bench for mem4x4_ctrl
module tb_mem4x4_ctrl;

    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic       rd_req;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       scan_en;
    logic [1:0] scan_addr;
    logic [3:0] scan_data;
    logic       scan_valid;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    mem4x4_ctrl dut (
        .clk_2     (clk_2),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .scan_en   (scan_en),
        .scan_addr (scan_addr),
        .scan_data (scan_data),
        .scan_valid(scan_valid),
        .busy      (busy)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_2);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [3:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        chk("wr_ack_early", wr_ack, 0);
        chk("wr_busy", busy, 1);
        step();
        chk("wr_ack", wr_ack, 1);
        wr_req = 1'b0;
        step();
        chk("wr_ack_drop", wr_ack, 0);
    endtask

    task automatic do_read(input logic [1:0] a, input logic [3:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        step();
        chk("rd_valid_early", rd_valid, 0);
        step();
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, exp);
        rd_req = 1'b0;
        step();
        chk("rd_valid_drop", rd_valid, 0);
    endtask

    initial begin
        logic [3:0] scan_exp [5];
        logic       seen;
        scan_exp[0] = 4'b0011; scan_exp[1] = 4'b0110; scan_exp[2] = 4'b1001;
        scan_exp[3] = 4'b1100; scan_exp[4] = 4'b0011;

        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 1'b0; rd_addr = '0; scan_en = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_scan_data", scan_data, 0);
        chk("rst_scan_addr", scan_addr, 0);

        // Free-running scan: a pulse every 6 cycles, walking the table and wrapping.
        rst_n   = 1'b1;
        scan_en = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int k = 1; k <= 6; k++) begin
                step();
                chk("scan_period", scan_valid, (k == 6) ? 1 : 0);
            end
            chk("scan_data_seq", scan_data, scan_exp[s]);
            chk("scan_addr_seq", scan_addr, (s + 1) % 4);
        end
        scan_en = 1'b0;
        step();

        // Write then read back, neighbour untouched.
        do_write(2'd2, 4'b0101);
        do_read(2'd2, 4'b0101);
        do_read(2'd1, 4'b0110);

        // Simultaneous write and read: write wins, read sees the new word.
        wr_req = 1'b1; wr_addr = 2'd1; wr_data = 4'b1111;
        rd_req = 1'b1; rd_addr = 2'd1;
        step();
        chk("both_ack0", wr_ack, 0);
        chk("both_valid0", rd_valid, 0);
        step();
        chk("both_wr_ack", wr_ack, 1);
        chk("both_no_overlap_a", rd_valid, 0);
        wr_req = 1'b0;
        step();
        chk("both_ack_drop", wr_ack, 0);
        chk("both_valid_wait", rd_valid, 0);
        step();
        chk("both_rd_valid", rd_valid, 1);
        chk("both_no_overlap_b", wr_ack, 0);
        chk("both_rd_data", rd_data, 4'b1111);
        rd_req = 1'b0;
        step();

        // Deferred scan: due reached while a read is pending.
        scan_en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rd_req = 1'b1; rd_addr = 2'd3;
        step();
        chk("defer_no_scan_a", scan_valid, 0);
        step();
        chk("defer_rd_valid", rd_valid, 1);
        chk("defer_rd_data", rd_data, 4'b1100);
        chk("defer_no_scan_b", scan_valid, 0);
        rd_req = 1'b0;
        step();
        chk("defer_scan_state", busy, 1);
        chk("defer_no_scan_c", scan_valid, 0);
        step();
        chk("defer_scan_valid", scan_valid, 1);
        chk("defer_scan_data", scan_data, 4'b1111);
        chk("defer_scan_addr", scan_addr, 2'd2);
        scan_en = 1'b0;
        step();
        chk("defer_scan_drop", scan_valid, 0);

        // Drop scan_en mid-count, then re-enable for a full count.
        scan_en = 1'b1;
        step(); step();
        scan_en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen = seen | scan_valid;
        end
        chk("off_no_scan", seen, 0);
        chk("off_scan_addr", scan_addr, 2'd2);
        chk("off_scan_data", scan_data, 4'b1111);
        scan_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("reen_period", scan_valid, (k == 6) ? 1 : 0);
        end
        chk("reen_scan_data", scan_data, 4'b0101);
        chk("reen_scan_addr", scan_addr, 2'd3);
        scan_en = 1'b0;
        step();

        // Asynchronous reset while in WR aborts the write.
        wr_req = 1'b1; wr_addr = 2'd0; wr_data = 4'b1010;
        step();
        chk("abort_in_wr", busy, 1);
        rst_n  = 1'b0;
        wr_req = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_wr_ack", wr_ack, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_scan_data", scan_data, 0);
        chk("abort_scan_addr", scan_addr, 0);
        step();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            seen = seen | wr_ack;
        end
        chk("abort_no_ack", seen, 0);
        do_read(2'd0, 4'b0011);
        do_read(2'd2, 4'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem4x4_ctrl.md
Name: mem4x4_ctrl

Overview:
- Controller and arbiter for the board's small 4-word x 4-bit lookup memory.
- Owns the storage, initialised to the standard lookup table.
- Shares one access slot per operation between three clients: a write port, a read port and an autonomous scan sequencer that cycles through all addresses to drive LED[7:4].
- Sits in top between the SWI decoding and the LED/LCD outputs.

Parameters:
ADDR_WIDTH, 2, address width (memory depth = 2**ADDR_WIDTH)
DATA_WIDTH, 4, word width
SCAN_DIV, 4, idle clock cycles between scan steps (>=1)

Ports:
clk_2  in  1  system clock
rst_n  in  1  asynchronous reset, active low
wr_req  in  1  write request, level, held until wr_ack
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_ack  out  1  one-cycle pulse: write committed
rd_req  in  1  read request, level, held until rd_valid
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data, holds last value
rd_valid  out  1  one-cycle pulse: rd_data updated
scan_en  in  1  enable autonomous scan
scan_addr  out  ADDR_WIDTH  address of the next scan step
scan_data  out  DATA_WIDTH  last scanned word, held
scan_valid  out  1  one-cycle pulse: scan_data updated
busy  out  1  state != IDLE (decoded from the state register)

Behaviour:
- Interface: one clock (clk_2); reset is asynchronous and active-low (rst_n).
- Reset: state IDLE; mem[0..3] = 0011, 0110, 1001, 1100.
- Reset clears wr_ack, rd_valid, scan_valid, rd_data, scan_data, scan_addr and the divider count to 0.
- Reset mid-operation aborts the operation: no memory update and no ack/valid pulse.
- FSM states:
  - IDLE: arbitrates.
  - WR, RD, SCAN: each lasts exactly one cycle, then returns to IDLE.
- Arbitration is sampled in IDLE only. Fixed priority: wr_req > rd_req > scan step due.
- Write:
  - The IDLE edge with wr_req=1 latches wr_addr/wr_data and moves to WR.
  - The next edge writes mem and asserts wr_ack for one cycle.
  - Latency: 2 edges from the request being sampled to the ack.
- Read:
  - The IDLE edge with rd_req=1 (and no wr_req) latches rd_addr and moves to RD.
  - The next edge loads rd_data = mem[addr] and pulses rd_valid.
- Request lifecycle:
  - A client must drop its request in the cycle its ack/valid is high.
  - A request still high at the following IDLE edge is a new request.
- Scan divider:
  - Counts only while scan_en=1 and state=IDLE, from 0 to SCAN_DIV-1.
  - At terminal count with no wr_req or rd_req, the edge moves to SCAN.
  - The following edge loads scan_data = mem[scan_addr], pulses scan_valid, increments scan_addr (wraps 3->0) and clears the divider.
- Deferral: if a request is pending at terminal count, the divider holds at terminal and the scan step runs at the first IDLE edge with no request pending. Scan steps are never dropped.
- scan_en=0: the divider clears; scan_addr and scan_data hold. A SCAN state already entered completes.
- Read-after-write to the same address, back to back, returns the new data.
- Data is never read and written in the same cycle (single-slot arbitration).
- Requests arriving while state != IDLE wait, because they are level-held.

Decomposition:
- Shared package mem4x4_pkg:
  - typedef state_t {IDLE, WR, RD, SCAN}
  - ADDR_WIDTH/DATA_WIDTH defaults
  - the reset table constant MEM_INIT.
- One natural sub-module: scan_divider (counter with enable, hold-at-terminal and clear; outputs the `due` signal).
- The memory array and FSM stay in mem4x4_ctrl.

Test Plan:
- Reset, then scan_en=1, SCAN_DIV=4, no requests -> scan_valid pulses every 6 cycles (4 count + SCAN + step edge); scan_data sequence 0011, 0110, 1001, 1100, 0011; scan_addr wraps 3->0.
- wr_req addr=2 data=0101 -> wr_ack exactly 2 edges later. Then rd_req addr=2 -> rd_data=0101 with rd_valid 2 edges after the request; mem[1] still reads 0110.
- wr_req and rd_req raised in the same cycle (wr 1<-1111, rd addr 1) -> write served first; read returns 1111 on a later rd_valid; no overlap of wr_ack and rd_valid.
- Scan at terminal count while rd_req is held high -> divider holds; scan_valid fires on the first request-free IDLE edge after rd_valid; no scan step is skipped (scan_addr advances by exactly 1).
- rst_n pulsed low during WR (addr 0 data 1010) -> wr_ack never asserted; mem[0] reads 0011; all outputs 0 immediately (asynchronous).
- scan_en dropped mid-count -> no scan_valid; scan_addr and scan_data unchanged. Re-enabling restarts a full SCAN_DIV count.
